fetch_queue_unit: RTL
=====================

Name: fetch_queue_unit

Overview:
- Parametrised successor of the single-entry PC/fetch stage.
- Prefetches sequential instructions from mem_control into a DEPTH-entry FIFO of {pc, inst} pairs.
- Issues FIFO entries to the decoder whenever the station reports idle.
- On an ROB jump: flushes the queue, drops any in-flight fetch, and redirects fetch.

Parameters:
ADDR_WIDTH, 32, width of PC and fetch address
INST_WIDTH, 32, instruction width
QUEUE_DEPTH, 4, FIFO entries; power of two, >= 2
PTR_WIDTH, 2, log2(QUEUE_DEPTH)
RESET_PC, 0, PC loaded on reset

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
rdy  input  1  global enable; when low, all state and outputs hold
if_output_pc  output  1  fetch request valid to mem_control
pc_to_getInst  output  ADDR_WIDTH  fetch address
if_gotInst  input  1  one-cycle pulse: inst_mem valid for the outstanding request
inst_mem  input  INST_WIDTH  fetched instruction
if_to_decoder  output  1  one-cycle pulse: inst_decoder/pc_decoder valid
inst_decoder  output  INST_WIDTH  issued instruction
pc_decoder  output  ADDR_WIDTH  PC of issued instruction
if_station_idle  input  1  decoder/station can accept an instruction this cycle
if_jump  input  1  ROB redirect
pc_to_jump  input  ADDR_WIDTH  redirect target
queue_count  output  PTR_WIDTH+1  current FIFO occupancy (debug/perf)

Behaviour:
- Reset (rst=1 at posedge):
  - PC, pc_to_getInst <= RESET_PC.
  - if_output_pc, if_to_decoder <= 0.
  - inst_decoder, pc_decoder <= 0.
  - Pointers, queue_count <= 0; FSM <= IDLE.
  - rst overrides rdy and if_jump; reset mid-fetch abandons the request, so no later if_gotInst is accepted until a new request is raised.
- rdy=0: nothing changes; a pulse on if_gotInst or if_jump in that cycle is ignored (mem_control and ROB hold while rdy is low).
- At most one outstanding request. Request allowed only when queue_count + 1 <= QUEUE_DEPTH, counting the entry freed by a same-cycle pop.
- FSM states:
  - IDLE: if space, drive if_output_pc=1, pc_to_getInst=PC -> WAIT.
  - WAIT: if_output_pc held 1 until if_gotInst. On if_gotInst: push {PC, inst_mem}; PC, pc_to_getInst <= PC+4 (modulo 2^ADDR_WIDTH, wraps silently).
    - Then, if space remains after this cycle's push/pop, stay in WAIT with the new address (back-to-back fetch).
    - Otherwise drop if_output_pc and go to IDLE.
  - FLUSH: if_output_pc=0 for exactly one cycle; any if_gotInst in this cycle is discarded. Next state IDLE.
- Issue: each cycle, if queue non-empty, if_station_idle=1 and no if_jump:
  - if_to_decoder <= 1; inst_decoder/pc_decoder <= head entry; pop.
  - Otherwise if_to_decoder <= 0 and inst_decoder/pc_decoder hold.
- Latency: instruction returned at edge N is issued at edge N+1 at the earliest (registered), i.e. decoder sees it in cycle N+1.
- Simultaneous push and pop: both occur; count unchanged. Push when full is impossible by construction (reservation rule). Pointers wrap modulo QUEUE_DEPTH.
- if_jump (highest priority after rst):
  - Pointers and count <= 0; if_to_decoder <= 0.
  - PC, pc_to_getInst <= pc_to_jump; if_output_pc <= 0.
  - FSM -> FLUSH if a request was outstanding (WAIT), else IDLE.
  - if_gotInst in the jump cycle is discarded.
  - Jump during FLUSH restarts FLUSH with the new target.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the queue is empty, if_gotInst arrives and if_station_idle=1 (no jump), the instruction is issued to the decoder at that same edge without being enqueued; PC advances as normal. Zero queue latency.
- Undefined: every instruction passes through the FIFO with a one-cycle minimum.

Test Plan:
- Reset with RESET_PC=0, then mem returns 4 insts at 2-cycle latency, station idle -> pc_decoder 0,4,8,12 issued in order, one cycle after each if_gotInst.
- Station idle=0, DEPTH=4, mem returns every cycle -> 4 entries queued; queue_count=4; if_output_pc low; raise idle -> issue 4 consecutive cycles, fetch resumes once a slot frees.
- Jump to 0x100 while WAIT, with if_gotInst pulsed the following cycle -> that inst discarded, queue empty, next request pc_to_getInst=0x100, first issued pc_decoder=0x100.
- Queue at 3, push and pop same cycle -> count stays 3, order preserved; PC=0xFFFFFFFC fetch -> next PC 0x0.
- rdy=0 for 5 cycles mid-WAIT -> all outputs frozen; resumes identically when rdy=1; rst asserted during WAIT -> outputs reset values next cycle.
- FETCH_BYPASS_EN defined, empty queue, idle station -> if_to_decoder at the if_gotInst edge; undefined -> one cycle later.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch queue bus: memory-side fetch handshake, decoder-side issue,
// ROB redirect and occupancy. The unit uses the master modport.
interface fetch_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int PTR_WIDTH  = 2
);
    logic                  rdy;
    logic                  if_output_pc;
    logic [ADDR_WIDTH-1:0] pc_to_getInst;
    logic                  if_gotInst;
    logic [INST_WIDTH-1:0] inst_mem;
    logic                  if_to_decoder;
    logic [INST_WIDTH-1:0] inst_decoder;
    logic [ADDR_WIDTH-1:0] pc_decoder;
    logic                  if_station_idle;
    logic                  if_jump;
    logic [ADDR_WIDTH-1:0] pc_to_jump;
    logic [PTR_WIDTH:0]    queue_count;

    modport master (
        input  rdy, if_gotInst, inst_mem, if_station_idle, if_jump, pc_to_jump,
        output if_output_pc, pc_to_getInst, if_to_decoder, inst_decoder,
               pc_decoder, queue_count
    );

    modport slave (
        output rdy, if_gotInst, inst_mem, if_station_idle, if_jump, pc_to_jump,
        input  if_output_pc, pc_to_getInst, if_to_decoder, inst_decoder,
               pc_decoder, queue_count
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Prefetching fetch stage: sequential fetches into a QUEUE_DEPTH-entry FIFO
// of {pc, inst}, issued to the decoder when the station is idle; ROB jumps
// flush the queue and redirect fetch.
// Optional macro FETCH_BYPASS_EN: issue straight from memory when the queue
// is empty and the station is idle (zero queue latency).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no request outstanding; raise one when a slot is available
// ST_WAIT  | request outstanding, if_output_pc high until if_gotInst
// ST_FLUSH | one dead cycle after a jump that abandoned a request;
//          | a late if_gotInst for the old request is dropped here
module fetch_queue_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INST_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter int PTR_WIDTH   = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    fetch_queue_if.master  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FLUSH} state_t;

    localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(QUEUE_DEPTH);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [PTR_WIDTH-1:0]  head_q;
    logic [PTR_WIDTH-1:0]  tail_q;
    logic [PTR_WIDTH:0]    count_q;
    logic [ADDR_WIDTH-1:0] pc_mem   [QUEUE_DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [QUEUE_DEPTH];

    logic                  got_fetch;
    logic                  do_pop;
    logic                  do_push;
    logic                  do_bypass;
    logic [PTR_WIDTH:0]    count_next;
    logic                  has_space;

    assign bus.queue_count = count_q;

    // Queue movement for this cycle, ignoring jump (handled by priority below).
    always_comb begin
        got_fetch  = (state_q == ST_WAIT) && bus.if_gotInst;
        do_pop     = (count_q != '0) && bus.if_station_idle;
`ifdef FETCH_BYPASS_EN
        do_bypass  = got_fetch && (count_q == '0) && bus.if_station_idle;
`else
        do_bypass  = 1'b0;
`endif
        do_push    = got_fetch && !do_bypass;
        count_next = count_q + {{PTR_WIDTH{1'b0}}, do_push}
                             - {{PTR_WIDTH{1'b0}}, do_pop};
        // The reservation counts the slot freed by a same-cycle pop.
        has_space  = count_next < DEPTH_CNT;
    end

    // FIFO storage write; no reset needed, occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (!rst && bus.rdy && !bus.if_jump && do_push) begin
            pc_mem[tail_q]   <= pc_q;
            inst_mem[tail_q] <= bus.inst_mem;
        end
    end

    // Control FSM, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            pc_q              <= RESET_PC;
            bus.pc_to_getInst <= RESET_PC;
            bus.if_output_pc  <= 1'b0;
            bus.if_to_decoder <= 1'b0;
            bus.inst_decoder  <= '0;
            bus.pc_decoder    <= '0;
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
        end else if (bus.rdy) begin
            if (bus.if_jump) begin
                head_q            <= '0;
                tail_q            <= '0;
                count_q           <= '0;
                bus.if_to_decoder <= 1'b0;
                pc_q              <= bus.pc_to_jump;
                bus.pc_to_getInst <= bus.pc_to_jump;
                bus.if_output_pc  <= 1'b0;
                // A response may still be in flight unless we were idle.
                state_q <= (state_q == ST_IDLE) ? ST_IDLE : ST_FLUSH;
            end else begin
                if (do_pop) begin
                    bus.if_to_decoder <= 1'b1;
                    bus.inst_decoder  <= inst_mem[head_q];
                    bus.pc_decoder    <= pc_mem[head_q];
                    head_q            <= head_q + PTR_WIDTH'(1);
                end else if (do_bypass) begin
                    bus.if_to_decoder <= 1'b1;
                    bus.inst_decoder  <= bus.inst_mem;
                    bus.pc_decoder    <= pc_q;
                end else begin
                    bus.if_to_decoder <= 1'b0;
                end

                if (do_push) begin
                    tail_q <= tail_q + PTR_WIDTH'(1);
                end
                count_q <= count_next;

                case (state_q)
                    ST_IDLE: begin
                        if (has_space) begin
                            bus.if_output_pc  <= 1'b1;
                            bus.pc_to_getInst <= pc_q;
                            state_q           <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (bus.if_gotInst) begin
                            pc_q              <= pc_q + ADDR_WIDTH'(4);
                            bus.pc_to_getInst <= pc_q + ADDR_WIDTH'(4);
                            if (!has_space) begin
                                bus.if_output_pc <= 1'b0;
                                state_q          <= ST_IDLE;
                            end
                        end
                    end
                    ST_FLUSH: begin
                        bus.if_output_pc <= 1'b0;
                        state_q          <= ST_IDLE;
                    end
                    default: begin
                        bus.if_output_pc <= 1'b0;
                        state_q          <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule
